// File: rtl/fuzzy_pi_sequencer.sv
// fuzzy_pi_sequencer
//   Loop-side front end for the fuzzy PI controller. On a sample tick it
//   captures setpoint/feedback, forms the scaled error e and error increment
//   de, hands them to the controller with a one-cycle start pulse, waits for
//   the controller's rdy, then integrates the result into a clamped actuator
//   command u.
//
//   Optional feature macro: FUZZY_SEQ_TIMEOUT_EN
//     defined   : WAIT gives up after TIMEOUT cycles, timeout_err set (sticky)
//     undefined : WAIT blocks until ctrl_rdy, timeout_err tied low
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   sample_en     one-cycle sample tick
//   clear_int     synchronous clear of integrator u and e_prev
//   sp, fb        setpoint / feedback, signed Q1.(N-1)
//   ctrl_x/ctrl_y error / error increment to controller (held through WAIT)
//   ctrl_start    one-cycle start pulse to controller
//   ctrl_out      controller result
//   ctrl_rdy      controller result-valid pulse (only honoured in WAIT)
//   u, u_valid    actuator command and its one-cycle update pulse
//   busy          high in any state other than IDLE
//   overrun       sticky: sample_en arrived while busy
//   timeout_err   sticky: controller failed to answer
`timescale 1ns/1ps

module fuzzy_pi_sequencer #(
    parameter int          N       = 16,
    parameter int          KE_SH   = 0,
    parameter int          KDE_SH  = 0,
    parameter int          KU_SH   = 0,
    parameter int unsigned U_LIM   = 'h4000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_en,
    input  logic         clear_int,
    input  logic [N-1:0] sp,
    input  logic [N-1:0] fb,
    output logic [N-1:0] ctrl_x,
    output logic [N-1:0] ctrl_y,
    output logic         ctrl_start,
    input  logic [N-1:0] ctrl_out,
    input  logic         ctrl_rdy,
    output logic [N-1:0] u,
    output logic         u_valid,
    output logic         busy,
    output logic         overrun,
    output logic         timeout_err
);

    // Working width: wide enough for the difference of two (N+1)-bit values
    // and for the largest left shift before saturation.
    localparam int SH_MAX = (KE_SH > KDE_SH) ? KE_SH : KDE_SH;
    localparam int WW     = N + 2 + SH_MAX;

    localparam logic signed [WW-1:0] SMAX   = {{(WW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [WW-1:0] SMIN   = {{(WW-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [WW-1:0] ULIM_P = WW'(U_LIM);
    localparam logic signed [WW-1:0] ULIM_N = -ULIM_P;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_START,
        S_WAIT,
        S_ACC
    } state_t;

    function automatic logic signed [WW-1:0] sext(input logic [N-1:0] x);
        return {{(WW-N){x[N-1]}}, x};
    endfunction

    function automatic logic signed [WW-1:0] sext1(input logic [N:0] x);
        return {{(WW-N-1){x[N]}}, x};
    endfunction

    function automatic logic [N-1:0] sat(input logic signed [WW-1:0] v);
        if (v > SMAX)
            return SMAX[N-1:0];
        else if (v < SMIN)
            return SMIN[N-1:0];
        else
            return v[N-1:0];
    endfunction

    state_t r_state;
    state_t w_next;
    logic   w_start;
    logic   w_busy;

    logic [N-1:0] r_sp;
    logic [N-1:0] r_fb;
    logic [N:0]   r_e_prev;     // unsaturated (N+1)-bit error of the previous sample
    logic [N-1:0] r_ctrl_x;
    logic [N-1:0] r_ctrl_y;
    logic [N-1:0] r_ctrl_out;
    logic [N-1:0] r_u;
    logic         r_u_valid;
    logic         r_overrun;

    logic signed [WW-1:0] w_raw;
    logic signed [WW-1:0] w_dd;
    logic [N-1:0]         w_e;
    logic [N-1:0]         w_de;
    logic [N-1:0]         w_e_s;
    logic [N-1:0]         w_de_s;
    logic signed [N-1:0]  w_inc;
    logic [N-1:0]         w_base;
    logic signed [WW-1:0] w_sum;
    logic [N-1:0]         w_u_next;
    logic                 w_tmo;

    // e_prev keeps the full (N+1)-bit difference, so a step out of hard
    // saturation yields a full-scale increment (e.g. +7FFF -> 0 gives 8000).
    assign w_raw  = sext(r_sp) - sext(r_fb);
    assign w_dd   = w_raw - sext1(r_e_prev);
    assign w_e    = sat(w_raw);
    assign w_de   = sat(w_dd);
    assign w_e_s  = sat(sext(w_e) <<< KE_SH);
    assign w_de_s = sat(sext(w_de) <<< KDE_SH);

    // A clear landing in the ACC cycle still lets the pending result add to 0.
    assign w_inc  = $signed(r_ctrl_out) >>> KU_SH;
    assign w_base = clear_int ? '0 : r_u;
    assign w_sum  = sext(w_base) + sext(w_inc);

    always_comb begin
        w_u_next = w_sum[N-1:0];
        if (w_sum > ULIM_P)
            w_u_next = ULIM_P[N-1:0];
        else if (w_sum < ULIM_N)
            w_u_next = ULIM_N[N-1:0];
    end

`ifdef FUZZY_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_cnt;
    logic          r_tmo_err;

    assign w_tmo = (r_cnt == TW'(TIMEOUT - 1));

    // Counter idles at 0 outside WAIT, so each WAIT visit starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (!ctrl_rdy && w_tmo)
                r_tmo_err <= 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (sample_en)
                    w_next = S_CALC;
            end
            S_CALC:  w_next = S_START;
            S_START: begin
                w_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (ctrl_rdy)
                    w_next = S_ACC;
                else if (w_tmo)
                    w_next = S_IDLE;
            end
            S_ACC:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ctrl_x/ctrl_y are loaded at the CALC->START edge so they are already
    // valid in the cycle ctrl_start is high, then held until the next sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp       <= '0;
            r_fb       <= '0;
            r_e_prev   <= '0;
            r_ctrl_x   <= '0;
            r_ctrl_y   <= '0;
            r_ctrl_out <= '0;
            r_u        <= '0;
            r_u_valid  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_u_valid <= 1'b0;
            if (sample_en && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            if (clear_int) begin
                r_u      <= '0;
                r_e_prev <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (sample_en) begin
                        r_sp <= sp;
                        r_fb <= fb;
                    end
                end
                S_CALC: begin
                    r_ctrl_x <= w_e_s;
                    r_ctrl_y <= w_de_s;
                    if (!clear_int)
                        r_e_prev <= w_raw[N:0];
                end
                S_WAIT: begin
                    if (ctrl_rdy)
                        r_ctrl_out <= ctrl_out;
                end
                S_ACC: begin
                    r_u       <= w_u_next;
                    r_u_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ctrl_x     = r_ctrl_x;
    assign ctrl_y     = r_ctrl_y;
    assign ctrl_start = w_start;
    assign u          = r_u;
    assign u_valid    = r_u_valid;
    assign busy       = w_busy;
    assign overrun    = r_overrun;

endmodule
